// File: rtl/dram_word_port_if.sv
// Bus bundle between a 32-bit word requester, the word port and the DDR controller.
// slave is the word port's view of the bundle; master is the requester/controller side.
interface dram_word_port_if #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
);
    logic                      i_req;
    logic                      i_we;
    logic [31:0]               i_addr;
    logic [31:0]               i_wdata;
    logic [3:0]                i_wstrb;
    logic                      i_flush;
    logic                      o_ack;
    logic [31:0]               o_rdata;
    logic                      o_dram_rd_en;
    logic                      o_dram_wr_en;
    logic [APP_ADDR_WIDTH-1:0] o_dram_addr;
    logic [APP_DATA_WIDTH-1:0] o_dram_data;
    logic [APP_MASK_WIDTH-1:0] o_dram_mask;
    logic                      i_dram_ready;
    logic [APP_DATA_WIDTH-1:0] i_dram_data;
    logic                      i_dram_data_valid;
    logic                      i_calib_done;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_wstrb, i_flush,
        input  i_dram_ready, i_dram_data, i_dram_data_valid, i_calib_done,
        output o_ack, o_rdata, o_dram_rd_en, o_dram_wr_en,
        output o_dram_addr, o_dram_data, o_dram_mask
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_wstrb, i_flush,
        output i_dram_ready, i_dram_data, i_dram_data_valid, i_calib_done,
        input  o_ack, o_rdata, o_dram_rd_en, o_dram_wr_en,
        input  o_dram_addr, o_dram_data, o_dram_mask
    );
endinterface

// File: rtl/dram_word_port.sv
// Turns 32-bit word accesses into 128-bit DDR line reads/writes, with a one-line
// read buffer that serves repeated reads locally; writes go straight through to DRAM.
module dram_word_port #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    dram_word_port_if.slave bus
);

    typedef enum logic [2:0] {
        CALIB, IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_GUARD, WR_WAIT, ACK
    } state_t;

    state_t                    state;
    logic [APP_DATA_WIDTH-1:0] line;
    logic [27:0]               tag;
    logic                      valid;
    logic                      flush_pend;
    logic                      wr_hit;

    logic [1:0]                lane;
    logic                      hit;
    logic [APP_MASK_WIDTH-1:0] wmask;
    logic [APP_DATA_WIDTH-1:0] merged;
    logic                      capture;
    logic                      merge;

    assign lane    = bus.i_addr[3:2];
    assign hit     = valid && (tag == bus.i_addr[31:4]);
    assign capture = (state == RD_WAIT) && bus.i_dram_data_valid;
    assign merge   = (state == WR_WAIT) && bus.i_dram_ready && wr_hit;

    // NOTE: every signal gets a default before the loop so no latch is inferred.
    always_comb begin
        wmask  = '1;
        merged = line;
        for (int k = 0; k < 4; k++) begin
            wmask[{lane, k[1:0]}] = ~bus.i_wstrb[k];
            if (bus.i_wstrb[k])
                merged[{lane, k[1:0], 3'b000} +: 8] = bus.i_wdata[8*k +: 8];
        end
    end

    // NOTE: the line data has no reset; valid alone decides whether it is usable.
    always_ff @(posedge clk) begin
        if (capture)
            line <= bus.i_dram_data;
        else if (merge)
            line <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= CALIB;
            tag              <= '0;
            valid            <= 1'b0;
            flush_pend       <= 1'b0;
            wr_hit           <= 1'b0;
            bus.o_ack        <= 1'b0;
            bus.o_rdata      <= '0;
            bus.o_dram_rd_en <= 1'b0;
            bus.o_dram_wr_en <= 1'b0;
            bus.o_dram_addr  <= '0;
            bus.o_dram_data  <= '0;
            bus.o_dram_mask  <= '0;
        end else begin
            bus.o_ack        <= 1'b0;
            bus.o_dram_rd_en <= 1'b0;
            bus.o_dram_wr_en <= 1'b0;
            // A flush while busy is remembered and applied when the access completes.
            if (bus.i_flush && state != IDLE && state != CALIB)
                flush_pend <= 1'b1;

            case (state)
                CALIB: begin
                    if (bus.i_calib_done)
                        state <= IDLE;
                end
                IDLE: begin
                    if (bus.i_flush)
                        valid <= 1'b0;
                    if (bus.i_req) begin
                        if (!bus.i_we && hit && !bus.i_flush) begin
                            bus.o_rdata <= line[{lane, 5'b00000} +: 32];
                            bus.o_ack   <= 1'b1;
                            state       <= ACK;
                        end else if (!bus.i_we) begin
                            state <= RD_ISSUE;
                        end else begin
                            wr_hit <= hit && !bus.i_flush;
                            state  <= WR_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bus.i_dram_ready) begin
                        bus.o_dram_rd_en <= 1'b1;
                        bus.o_dram_addr  <= {bus.i_addr[APP_ADDR_WIDTH:4], 3'b000};
                        state            <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.i_dram_data_valid) begin
                        tag         <= bus.i_addr[31:4];
                        valid       <= !(flush_pend || bus.i_flush);
                        bus.o_rdata <= bus.i_dram_data[{lane, 5'b00000} +: 32];
                        bus.o_ack   <= 1'b1;
                        state       <= ACK;
                    end
                end
                WR_ISSUE: begin
                    if (bus.i_dram_ready) begin
                        bus.o_dram_wr_en <= 1'b1;
                        bus.o_dram_addr  <= {bus.i_addr[APP_ADDR_WIDTH:4], 3'b000};
                        bus.o_dram_data  <= {4{bus.i_wdata}};
                        bus.o_dram_mask  <= wmask;
                        state            <= WR_GUARD;
                    end
                end
                // Ready is still high from the acceptance cycle; skip it.
                WR_GUARD: state <= WR_WAIT;
                WR_WAIT: begin
                    if (bus.i_dram_ready) begin
                        bus.o_ack <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (flush_pend || bus.i_flush)
                        valid <= 1'b0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= CALIB;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_port.sv
// Randomised bench for dram_word_port: a DRAM controller model plus a line-buffer
// reference model predict hit/miss, read data, write masks and ack timing.
module tb_dram_word_port;

    logic clk;
    logic rst;

    dram_word_port_if bus ();

    dram_word_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory and line-buffer reference state
    logic [127:0] mem [int];
    logic         m_valid = 1'b0;
    logic [27:0]  m_tag   = '0;

    function automatic logic [127:0] get_line(input int idx);
        if (!mem.exists(idx))
            mem[idx] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mem[idx];
    endfunction

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor, sampled on the falling edge
    int           rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;
    logic         ready_dropped = 1'b0;
    logic [27:0]  cap_addr;
    logic [127:0] cap_data;
    logic [15:0]  cap_mask;

    always @(negedge clk) begin
        if (bus.o_dram_rd_en || bus.o_dram_wr_en) begin
            check("pulse_while_ready", bus.i_dram_ready, 1'b1);
            check("pulse_exclusive", bus.o_dram_rd_en && bus.o_dram_wr_en, 1'b0);
        end
        if (bus.o_dram_rd_en) begin
            rd_cnt++;
            cap_addr = bus.o_dram_addr;
        end
        if (bus.o_dram_wr_en) begin
            wr_cnt++;
            cap_addr = bus.o_dram_addr;
            cap_data = bus.o_dram_data;
            cap_mask = bus.o_dram_mask;
        end
        if (wr_cnt > 0 && !bus.i_dram_ready)
            ready_dropped = 1'b1;
        if (bus.o_ack)
            ack_cnt++;
    end

    // DRAM controller model
    logic        flush_in_wait = 1'b0;
    logic        abort_rd      = 1'b0;
    logic        long_delay    = 1'b0;
    int unsigned dv_cyc        = 0;

    initial begin
        int           d;
        logic [127:0] ln;
        bus.i_dram_ready      = 1'b1;
        bus.i_dram_data_valid = 1'b0;
        bus.i_dram_data       = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.o_dram_rd_en) begin
                ln = get_line(int'(bus.o_dram_addr[27:3]));
                @(posedge clk); #1;
                bus.i_dram_ready = 1'b0;
                if (flush_in_wait) begin
                    bus.i_flush = 1'b1;
                    @(posedge clk); #1;
                    bus.i_flush = 1'b0;
                end
                d = long_delay ? 12 : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                if (!abort_rd) begin
                    bus.i_dram_data_valid = 1'b1;
                    bus.i_dram_data       = ln;
                    dv_cyc                = cyc;
                    @(posedge clk); #1;
                    bus.i_dram_data_valid = 1'b0;
                end
                bus.i_dram_ready = 1'b1;
            end else if (bus.o_dram_wr_en) begin
                @(posedge clk); #1;
                bus.i_dram_ready = 1'b0;
                d = int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                bus.i_dram_ready = 1'b1;
            end
        end
    end

    logic [31:0] last_rdata;

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic flush_now, input logic flush_wait,
                          input string name);
        int           idx;
        int           lane;
        logic         exp_hit;
        logic         got_ack;
        int           n;
        int unsigned  ack_cyc;
        logic [127:0] ln;
        logic [15:0]  exp_mask;
        idx  = int'(addr[28:4]);
        lane = int'(addr[3:2]);
        if (flush_now)
            m_valid = 1'b0;
        exp_hit       = m_valid && (m_tag == addr[31:4]);
        rd_cnt        = 0;
        wr_cnt        = 0;
        ready_dropped = 1'b0;
        flush_in_wait = flush_wait && !we;
        bus.i_req   = 1'b1;
        bus.i_we    = we;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        bus.i_wstrb = wstrb;
        bus.i_flush = flush_now;
        got_ack = 1'b0;
        n       = 0;
        ack_cyc = 0;
        while (!got_ack && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1)
                bus.i_flush = 1'b0;
            if (bus.o_ack) begin
                got_ack    = 1'b1;
                ack_cyc    = cyc;
                last_rdata = bus.o_rdata;
            end
        end
        bus.i_req     = 1'b0;
        flush_in_wait = 1'b0;
        check({name, "_ack"}, got_ack, 1'b1);
        if (got_ack) begin
            if (!we) begin
                ln = get_line(idx);
                check({name, "_rdata"}, last_rdata, ln[32*lane +: 32]);
                if (exp_hit) begin
                    check({name, "_hit_latency"}, n, 1);
                    check({name, "_hit_no_rd"}, rd_cnt, 0);
                end else begin
                    check({name, "_miss_rd_cnt"}, rd_cnt, 1);
                    check({name, "_rd_addr"}, cap_addr, {addr[28:4], 3'b000});
                    check({name, "_ack_after_dv"}, ack_cyc, dv_cyc + 1);
                    m_valid = !flush_wait;
                    m_tag   = addr[31:4];
                end
            end else begin
                exp_mask = 16'hFFFF;
                ln       = get_line(idx);
                for (int k = 0; k < 4; k++) begin
                    if (wstrb[k]) begin
                        exp_mask[4*lane + k]      = 1'b0;
                        ln[32*lane + 8*k +: 8]    = wdata[8*k +: 8];
                    end
                end
                mem[idx] = ln;
                check({name, "_wr_cnt"}, wr_cnt, 1);
                check({name, "_wr_no_rd"}, rd_cnt, 0);
                check({name, "_wr_addr"}, cap_addr, {addr[28:4], 3'b000});
                check({name, "_wr_data"}, cap_data, {4{wdata}});
                check({name, "_wr_mask"}, cap_mask, exp_mask);
                check({name, "_ack_after_ready_drop"}, ready_dropped, 1'b1);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        we;
        logic [31:0] addr;
        int          line_sel;

        rst                  = 1'b1;
        bus.i_req            = 1'b0;
        bus.i_we             = 1'b0;
        bus.i_addr           = '0;
        bus.i_wdata          = '0;
        bus.i_wstrb          = '0;
        bus.i_flush          = 1'b0;
        bus.i_calib_done     = 1'b0;
        mem[32'h10] = 128'h33333333_22222222_11111111_00000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.o_ack, bus.o_rdata, bus.o_dram_rd_en, bus.o_dram_wr_en,
              bus.o_dram_addr, bus.o_dram_mask}, '0);
        check("reset_dram_data", bus.o_dram_data, '0);
        rst = 1'b0;

        // Requests are ignored until calibration completes
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0104;
        rd_cnt = 0; wr_cnt = 0; ack_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check("calib_no_ack", ack_cnt, 0);
        check("calib_no_dram", rd_cnt + wr_cnt, 0);
        bus.i_req        = 1'b0;
        bus.i_calib_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        access(1'b0, 32'h0000_0104, '0, '0, 1'b0, 1'b0, "rd104_miss");
        check("rd104_value", last_rdata, 32'h1111_1111);
        check("rd104_dram_addr", cap_addr, 28'h0000080);
        access(1'b0, 32'h0000_0108, '0, '0, 1'b0, 1'b0, "rd108_hit");
        check("rd108_value", last_rdata, 32'h2222_2222);
        access(1'b1, 32'h0000_010C, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, "wr10c_hit");
        access(1'b0, 32'h0000_010C, '0, '0, 1'b0, 1'b0, "rd10c_hit");
        check("rd10c_merged", last_rdata, 32'h3333_BEEF);
        access(1'b1, 32'h0000_2000, $urandom(), 4'b1111, 1'b0, 1'b0, "wr2000_miss");
        access(1'b0, 32'h0000_0104, '0, '0, 1'b0, 1'b0, "rd104_still_hit");
        access(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0000, 1'b0, 1'b0, "wr_zero_strb");
        access(1'b0, 32'h0000_3004, '0, '0, 1'b0, 1'b1, "rd3004_flush_wait");
        access(1'b0, 32'h0000_3004, '0, '0, 1'b0, 1'b0, "rd3004_refetch");
        access(1'b0, 32'h0000_3008, '0, '0, 1'b1, 1'b0, "rd3008_flush_same");

        // Reset while waiting for read data
        long_delay = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_we   = 1'b0;
        bus.i_addr = 32'h0000_0504;
        rd_cnt     = 0;
        n          = 0;
        while (rd_cnt == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstwait_rd_issued", rd_cnt, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rstwait_outputs", {bus.o_ack, bus.o_rdata, bus.o_dram_rd_en, bus.o_dram_wr_en,
              bus.o_dram_addr, bus.o_dram_mask}, '0);
        check("rstwait_dram_data", bus.o_dram_data, '0);
        abort_rd         = 1'b1;
        bus.i_req        = 1'b0;
        bus.i_calib_done = 1'b0;
        m_valid          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        abort_rd         = 1'b0;
        long_delay       = 1'b0;
        bus.i_calib_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 32'h0000_0504, '0, '0, 1'b0, 1'b0, "rd504_after_rst");

        // Randomised mix over a small pool of lines so hits and misses both occur
        for (int t = 0; t < 150; t++) begin
            we       = ($urandom_range(0, 2) == 0);
            line_sel = int'($urandom_range(0, 6));
            addr     = (line_sel == 6) ? 32'h0000_2000 : (32'h0000_0100 + 32'(line_sel) * 16);
            addr     = addr | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            access(we, addr, $urandom(), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
